br_flow_token_bucket: RTL and testbench

Token-bucket rate limiter that gates a valid/ready flow and drives a saturating br_counter as its token store.
- Each accepted transfer consumes one token.
- A programmable period timer refills tokens.
- Sits in front of any br_flow-style consumer that must be bandwidth-capped: throttled datapath ingress, credit-return shaping.

---
 rtl/br_flow_token_bucket_pkg.sv | 7 +
 rtl/br_counter.sv | 35 +++
 rtl/br_flow_token_bucket_timer.sv | 22 ++
 rtl/br_flow_token_bucket.sv | 75 +++++++
 tb/tb_br_flow_token_bucket.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/br_flow_token_bucket_pkg.sv
// br_flow_token_bucket_pkg: default configuration constants for the token-bucket rate limiter.
package br_flow_token_bucket_pkg;
    localparam int DefaultWidth = 1;
    localparam int DefaultMaxTokens = 8;
    localparam int DefaultMaxRefill = 1;
    localparam int DefaultMaxPeriod = 16;
endpackage

// File: rtl/br_counter.sv
// br_counter: up/down counter with per-cycle increment and decrement, optional saturation or wrap.
module br_counter #(
    parameter int MaxValue = 1,
    parameter int MaxIncrement = 1,
    parameter int MaxDecrement = 1,
    parameter bit EnableSaturate = 0,
    parameter bit EnableWrap = 1,
    localparam int ValueWidth = $clog2(MaxValue + 1),
    localparam int IncrWidth = $clog2(MaxIncrement + 1),
    localparam int DecrWidth = $clog2(MaxDecrement + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reinit,
    input  logic [ValueWidth-1:0] initial_value,
    input  logic                  incr_valid,
    input  logic [IncrWidth-1:0]  incr,
    input  logic                  decr_valid,
    input  logic [DecrWidth-1:0]  decr,
    output logic [ValueWidth-1:0] value
);
    localparam int W = ValueWidth + IncrWidth + DecrWidth + 1;
    logic [W-1:0] up, dn, nxt;
    always_comb begin
        up = W'(value) + (incr_valid ? W'(incr) : '0);
        dn = decr_valid ? W'(decr) : '0;
        nxt = up < dn ? (EnableWrap ? up + W'(MaxValue + 1) - dn : '0)
            : up - dn > W'(MaxValue) ? (EnableSaturate ? W'(MaxValue) : up - dn - W'(MaxValue + 1))
            : up - dn;
    end
    always_ff @(posedge clk) begin
        if (rst || reinit) value <= initial_value;
        else value <= ValueWidth'(nxt);
    end
endmodule

// File: rtl/br_flow_token_bucket_timer.sv
// br_flow_token_bucket_timer: free-running refill timer, pulses refill once every period cycles.
module br_flow_token_bucket_timer
    import br_flow_token_bucket_pkg::*;
#(
    parameter int MaxPeriod = DefaultMaxPeriod,
    localparam int PeriodWidth = $clog2(MaxPeriod + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PeriodWidth-1:0] period,
    output logic                   refill
);
    logic [PeriodWidth-1:0] timer;
    logic [PeriodWidth:0] timer_inc;
    // >= rather than == so a period shrunk below the current phase still fires
    assign timer_inc = (PeriodWidth + 1)'(timer) + (PeriodWidth + 1)'(1);
    assign refill = period != '0 && timer_inc >= (PeriodWidth + 1)'(period);
    always_ff @(posedge clk) begin
        if (rst) timer <= '0;
        else timer <= (refill || period == '0) ? '0 : PeriodWidth'(timer_inc);
    end
endmodule

// File: rtl/br_flow_token_bucket.sv
// br_flow_token_bucket: token-bucket rate limiter on a valid/ready flow.
// Optional BR_FLOW_TOKEN_BUCKET_STALL_COUNT_EN adds a saturating stall_cycles counter.
module br_flow_token_bucket
    import br_flow_token_bucket_pkg::*;
#(
    parameter int Width = DefaultWidth,
    parameter int MaxTokens = DefaultMaxTokens,
    parameter int MaxRefill = DefaultMaxRefill,
    parameter int MaxPeriod = DefaultMaxPeriod,
    localparam int TokenWidth = $clog2(MaxTokens + 1),
    localparam int RefillWidth = $clog2(MaxRefill + 1),
    localparam int PeriodWidth = $clog2(MaxPeriod + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PeriodWidth-1:0] period,
    input  logic [RefillWidth-1:0] refill_amount,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [Width-1:0]       push_data,
    output logic                   pop_valid,
    input  logic                   pop_ready,
    output logic [Width-1:0]       pop_data,
    output logic [TokenWidth-1:0]  tokens,
    output logic                   refill
`ifdef BR_FLOW_TOKEN_BUCKET_STALL_COUNT_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);
    logic has_token, consume;
    assign has_token = tokens != '0;
    assign pop_valid = push_valid && has_token;
    assign push_ready = pop_ready && has_token;
    assign pop_data = push_data;
    assign consume = push_valid && push_ready;

    br_flow_token_bucket_timer #(.MaxPeriod(MaxPeriod)) u_timer (
        .clk(clk),
        .rst(rst),
        .period(period),
        .refill(refill)
    );

    br_counter #(
        .MaxValue(MaxTokens),
        .MaxIncrement(MaxRefill),
        .MaxDecrement(1),
        .EnableSaturate(1),
        .EnableWrap(0)
    ) u_tokens (
        .clk(clk),
        .rst(rst),
        .reinit(1'b0),
        .initial_value(TokenWidth'(MaxTokens)),
        .incr_valid(refill),
        .incr(refill_amount),
        .decr_valid(consume),
        .decr(1'b1),
        .value(tokens)
    );

`ifdef BR_FLOW_TOKEN_BUCKET_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= '0;
        else if (push_valid && !has_token && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
    end
`endif

    a_refill_range: assert property (@(posedge clk) disable iff (rst) refill_amount <= RefillWidth'(MaxRefill));
    a_period_range: assert property (@(posedge clk) disable iff (rst) period <= PeriodWidth'(MaxPeriod));
    a_push_stable: assert property (@(posedge clk) disable iff (rst) push_valid && !push_ready |=> push_valid);
    a_tokens_range: assert property (@(posedge clk) disable iff (rst) tokens <= TokenWidth'(MaxTokens));
    a_no_token_gate: assert property (@(posedge clk) disable iff (rst) !has_token |-> !pop_valid && !push_ready);
endmodule

// File: tb/tb_br_flow_token_bucket.sv
// tb_br_flow_token_bucket: directed self-checking bench for br_flow_token_bucket.
module tb_br_flow_token_bucket;
    logic clk = 0;
    logic rst = 1;
    logic [4:0] period;
    logic [2:0] refill_amount;
    logic push_valid, pop_ready, push_ready, pop_valid, refill;
    logic [7:0] push_data, pop_data;
    logic [3:0] tokens;
`ifdef BR_FLOW_TOKEN_BUCKET_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    br_flow_token_bucket #(.Width(8), .MaxTokens(8), .MaxRefill(4), .MaxPeriod(16)) dut (
        .clk(clk),
        .rst(rst),
        .period(period),
        .refill_amount(refill_amount),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_data(push_data),
        .pop_valid(pop_valid),
        .pop_ready(pop_ready),
        .pop_data(pop_data),
        .tokens(tokens),
        .refill(refill)
`ifdef BR_FLOW_TOKEN_BUCKET_STALL_COUNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1;
        push_valid = 0;
        pop_ready = 0;
        tick;
        tick;
        rst = 0;
    endtask

    initial begin
        period = 0;
        refill_amount = 0;
        push_valid = 0;
        pop_ready = 0;
        push_data = 0;
        do_reset;
        #1;
        chk("reset_tokens", 32'(tokens), 8);
        chk("reset_refill", 32'(refill), 0);
        chk("reset_pop_valid", 32'(pop_valid), 0);
        chk("reset_push_ready", 32'(push_ready), 0);

        // drain a full bucket with refill disabled
        push_valid = 1;
        pop_ready = 1;
        for (int i = 0; i < 8; i++) begin
            push_data = 8'(160 + i);
            #1;
            chk("drain_tokens", 32'(tokens), 32'(8 - i));
            chk("drain_pop_valid", 32'(pop_valid), 1);
            chk("drain_pop_data", 32'(pop_data), 32'(160 + i));
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("empty_pop_valid", 32'(pop_valid), 0);
            chk("empty_push_ready", 32'(push_ready), 0);
            chk("empty_tokens", 32'(tokens), 0);
            tick;
        end

        // one token every 4 cycles, consumed immediately
        period = 4;
        refill_amount = 1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk("rate_refill", 32'(refill), 32'(k % 4 == 3));
            chk("rate_tokens", 32'(tokens), 32'(k % 4 == 0 && k > 0));
            chk("rate_pop_valid", 32'(pop_valid), 32'(k % 4 == 0 && k > 0));
            tick;
        end

        // refill while full leaves tokens saturated
        do_reset;
        period = 2;
        refill_amount = 3;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("full_refill", 32'(refill), 32'(k % 2 == 1));
            chk("full_tokens", 32'(tokens), 8);
            tick;
        end

        // refill and consume in the same cycle at tokens=1
        period = 0;
        do_reset;
        push_valid = 1;
        pop_ready = 1;
        repeat (7) tick;
        #1;
        chk("both_pre_tokens", 32'(tokens), 1);
        period = 1;
        refill_amount = 2;
        #1;
        chk("both_refill", 32'(refill), 1);
        chk("both_pop_valid", 32'(pop_valid), 1);
        tick;
        period = 0;
        #1;
        chk("both_post_tokens", 32'(tokens), 2);
        chk("both_post_pop_valid", 32'(pop_valid), 1);

        // period shrinks below the running timer phase
        period = 16;
        refill_amount = 1;
        do_reset;
        repeat (10) tick;
        #1;
        chk("shrink_pre_refill", 32'(refill), 0);
        period = 4;
        #1;
        chk("shrink_refill", 32'(refill), 1);
        tick;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("shrink_cadence", 32'(refill), 32'(k % 4 == 0));
            chk("shrink_tokens", 32'(tokens), 8);
            tick;
        end

        // pop_valid independent of pop_ready; one accepted transfer
        period = 0;
        push_valid = 1;
        pop_ready = 0;
        #1;
        chk("bp_pop_valid", 32'(pop_valid), 1);
        chk("bp_push_ready", 32'(push_ready), 0);
        tick;
        #1;
        chk("bp_tokens_held", 32'(tokens), 8);
        pop_ready = 1;
        #1;
        chk("bp_push_ready_on", 32'(push_ready), 1);
        tick;
        push_valid = 0;
        #1;
        chk("bp_tokens_after", 32'(tokens), 7);
        chk("bp_pop_valid_off", 32'(pop_valid), 0);

`ifdef BR_FLOW_TOKEN_BUCKET_STALL_COUNT_EN
        do_reset;
        #1;
        chk("stall_reset", 32'(stall_cycles), 0);
        push_valid = 1;
        pop_ready = 1;
        repeat (8) tick;
        repeat (5) tick;
        #1;
        chk("stall_count", 32'(stall_cycles), 5);
        chk("stall_tokens", 32'(tokens), 0);
        rst = 1;
        push_valid = 0;
        tick;
        rst = 0;
        #1;
        chk("stall_cleared", 32'(stall_cycles), 0);
        chk("stall_rst_tokens", 32'(tokens), 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
